// File: rtl/xxv_tx_ts_matcher.sv
// XXV TX 2-step timestamp matcher: pairs returned timestamps with armed
// tags, classifies each event and streams one record per event.
module xxv_tx_ts_matcher #(
    parameter int PEND_DEPTH  = 8,
    parameter int OUT_DEPTH   = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic         tx_eth_clk,
    input  logic         tx_eth_rst,
    input  logic [31:0]  ctrl_mon_tdata,
    input  logic         ctrl_mon_tvalid,
    input  logic         ctrl_mon_tready,
    input  logic [95:0]  tx_ts_tdata,
    input  logic         tx_ts_tvalid,
    output logic [127:0] rec_tdata,
    output logic         rec_tvalid,
    output logic         rec_tlast,
    input  logic         rec_tready,
    output logic [6:0]   pend_level,
    output logic [15:0]  cnt_match,
    output logic [15:0]  cnt_mismatch,
    output logic [15:0]  cnt_timeout,
    output logic [15:0]  cnt_orphan,
    output logic [15:0]  cnt_drop
);
    localparam int PAW = $clog2(PEND_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam logic [PAW:0] PEND_MAX = (PAW+1)'(PEND_DEPTH);
    localparam logic [PAW:0] PEND_ONE = (PAW+1)'(1);
    localparam logic [OAW:0] OUT_MAX  = (OAW+1)'(OUT_DEPTH);
    localparam logic [23:0]  AGE_LAST = 24'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state_q, state_d;

    logic [15:0]    pend_mem [PEND_DEPTH];
    logic [PAW-1:0] pend_rd, pend_wr;
    logic [PAW:0]   pend_cnt;
    logic [23:0]    age;
    logic [15:0]    head, ts_tag;
    logic           arm, push, pend_drop;
    logic           ts_hit, tmo, orphan, pop;
    logic           unused_ok;

    assign unused_ok = ^ctrl_mon_tdata[15:2];
    assign ts_tag    = tx_ts_tdata[95:80];
    assign head      = pend_mem[pend_rd];
    assign arm       = ctrl_mon_tvalid & ctrl_mon_tready &
                       (ctrl_mon_tdata[1:0] != 2'd0);
    assign push      = arm & (pend_cnt != PEND_MAX);
    assign pend_drop = arm & (pend_cnt == PEND_MAX);
    assign pop       = ts_hit | tmo;
    assign pend_level = 7'(pend_cnt);

    always_ff @(posedge tx_eth_clk) begin
        if (tx_eth_rst) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (push) state_d = WAIT;
            WAIT:    if (pop && !push && pend_cnt == PEND_ONE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A ts beat always pre-empts a timeout landing in the same cycle.
    always_comb begin
        ts_hit = 1'b0;
        tmo    = 1'b0;
        orphan = 1'b0;
        unique case (state_q)
            IDLE: orphan = tx_ts_tvalid;
            WAIT: begin
                ts_hit = tx_ts_tvalid;
                tmo    = !tx_ts_tvalid && (age == AGE_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge tx_eth_clk) begin
        if (tx_eth_rst) begin
            pend_rd  <= '0;
            pend_wr  <= '0;
            pend_cnt <= '0;
            age      <= '0;
        end else begin
            if (push) pend_wr <= pend_wr + 1'b1;
            if (pop)  pend_rd <= pend_rd + 1'b1;
            if (push && !pop)      pend_cnt <= pend_cnt + 1'b1;
            else if (!push && pop) pend_cnt <= pend_cnt - 1'b1;
            if (state_q == WAIT && !pop) age <= age + 1'b1;
            else                         age <= '0;
        end
    end

    always_ff @(posedge tx_eth_clk) begin
        if (push) pend_mem[pend_wr] <= ctrl_mon_tdata[31:16];
    end

    logic        st_vld;
    logic [3:0]  st_code;
    logic [15:0] st_exp, st_rx;
    logic [79:0] st_ts;
    logic [11:0] seq;

    always_ff @(posedge tx_eth_clk) begin
        if (tx_eth_rst) begin
            st_vld  <= 1'b0;
            st_code <= '0;
            st_exp  <= '0;
            st_rx   <= '0;
            st_ts   <= '0;
            seq     <= '0;
        end else begin
            st_vld <= ts_hit | tmo | orphan;
            if (ts_hit) begin
                st_code <= (ts_tag == head) ? 4'd0 : 4'd1;
                st_exp  <= head;
                st_rx   <= ts_tag;
                st_ts   <= tx_ts_tdata[79:0];
            end else if (tmo) begin
                st_code <= 4'd2;
                st_exp  <= head;
                st_rx   <= '0;
                st_ts   <= '0;
            end else if (orphan) begin
                st_code <= 4'd3;
                st_exp  <= '0;
                st_rx   <= ts_tag;
                st_ts   <= tx_ts_tdata[79:0];
            end
            if (st_vld) seq <= seq + 1'b1;
        end
    end

    logic [127:0]   out_mem [OUT_DEPTH];
    logic [OAW-1:0] out_rp, out_wp;
    logic [OAW:0]   out_cnt;
    logic           out_wr, out_rd, out_drop;

    assign out_wr     = st_vld & (out_cnt != OUT_MAX);
    assign out_drop   = st_vld & (out_cnt == OUT_MAX);
    assign rec_tvalid = (out_cnt != '0);
    assign rec_tlast  = rec_tvalid;
    assign out_rd     = rec_tvalid & rec_tready;
    assign rec_tdata  = rec_tvalid ? out_mem[out_rp] : '0;

    always_ff @(posedge tx_eth_clk) begin
        if (tx_eth_rst) begin
            out_rp  <= '0;
            out_wp  <= '0;
            out_cnt <= '0;
        end else begin
            if (out_wr) out_wp <= out_wp + 1'b1;
            if (out_rd) out_rp <= out_rp + 1'b1;
            if (out_wr && !out_rd)      out_cnt <= out_cnt + 1'b1;
            else if (!out_wr && out_rd) out_cnt <= out_cnt - 1'b1;
        end
    end

    always_ff @(posedge tx_eth_clk) begin
        if (out_wr) out_mem[out_wp] <= {seq, st_code, st_exp, st_rx, st_ts};
    end

    always_ff @(posedge tx_eth_clk) begin
        if (tx_eth_rst) begin
            cnt_match    <= '0;
            cnt_mismatch <= '0;
            cnt_timeout  <= '0;
            cnt_orphan   <= '0;
            cnt_drop     <= '0;
        end else begin
            if (ts_hit && ts_tag == head) cnt_match    <= cnt_match + 1'b1;
            if (ts_hit && ts_tag != head) cnt_mismatch <= cnt_mismatch + 1'b1;
            if (tmo)    cnt_timeout <= cnt_timeout + 1'b1;
            if (orphan) cnt_orphan  <= cnt_orphan + 1'b1;
            cnt_drop <= cnt_drop + 16'(pend_drop) + 16'(out_drop);
        end
    end
endmodule

// File: tb/tb_xxv_tx_ts_matcher.sv
// Randomised scoreboard bench for xxv_tx_ts_matcher with a queue-based
// reference model and directed corner-case phases.
module tb_xxv_tx_ts_matcher;
    localparam int PD = 8;
    localparam int OD = 16;
    localparam int TO = 100;

    logic         clk, rst;
    logic [31:0]  ctrl_tdata;
    logic         ctrl_tvalid, ctrl_tready;
    logic [95:0]  ts_tdata;
    logic         ts_tvalid;
    logic [127:0] rec_tdata;
    logic         rec_tvalid, rec_tlast, rec_tready;
    logic [6:0]   pend_level;
    logic [15:0]  cnt_match, cnt_mismatch, cnt_timeout, cnt_orphan, cnt_drop;

    xxv_tx_ts_matcher #(.PEND_DEPTH(PD), .OUT_DEPTH(OD), .TIMEOUT_CYC(TO)) dut (
        .tx_eth_clk(clk), .tx_eth_rst(rst),
        .ctrl_mon_tdata(ctrl_tdata), .ctrl_mon_tvalid(ctrl_tvalid),
        .ctrl_mon_tready(ctrl_tready),
        .tx_ts_tdata(ts_tdata), .tx_ts_tvalid(ts_tvalid),
        .rec_tdata(rec_tdata), .rec_tvalid(rec_tvalid), .rec_tlast(rec_tlast),
        .rec_tready(rec_tready), .pend_level(pend_level),
        .cnt_match(cnt_match), .cnt_mismatch(cnt_mismatch),
        .cnt_timeout(cnt_timeout), .cnt_orphan(cnt_orphan), .cnt_drop(cnt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pending tags, output occupancy and counters.
    logic [15:0]  pq[$];
    logic [127:0] sb[$];
    int           age_m, mocc;
    bit           st_v;
    logic [115:0] st_body;
    logic [11:0]  mseq;
    logic [15:0]  m_match, m_mismatch, m_timeout, m_orphan, m_drop;

    always @(negedge clk) begin : model_p
        bit full, popo;
        int psz;
        logic [15:0] e, tg;
        if (rst) begin
            pq.delete(); sb.delete();
            age_m = 0; mocc = 0; st_v = 0; mseq = 0;
            m_match = 0; m_mismatch = 0; m_timeout = 0; m_orphan = 0; m_drop = 0;
        end else begin
            full = (mocc == OD);
            popo = rec_tready && mocc > 0;
            if (st_v) begin
                if (full) m_drop++;
                else      sb.push_back({mseq, st_body});
                mseq++;
            end
            mocc = mocc + ((st_v && !full) ? 1 : 0) - (popo ? 1 : 0);
            st_v = 0;
            psz = pq.size();
            tg = ts_tdata[95:80];
            if (ts_tvalid) begin
                st_v = 1;
                if (psz > 0) begin
                    e = pq.pop_front();
                    age_m = 0;
                    if (e == tg) begin m_match++; st_body = {4'd0, e, tg, ts_tdata[79:0]}; end
                    else begin m_mismatch++; st_body = {4'd1, e, tg, ts_tdata[79:0]}; end
                end else begin
                    m_orphan++;
                    st_body = {4'd3, 16'd0, tg, ts_tdata[79:0]};
                end
            end else if (psz > 0 && age_m == TO - 1) begin
                e = pq.pop_front();
                age_m = 0;
                m_timeout++;
                st_v = 1;
                st_body = {4'd2, e, 16'd0, 80'd0};
            end else if (psz > 0) begin
                age_m++;
            end
            if (ctrl_tvalid && ctrl_tready && ctrl_tdata[1:0] != 2'd0) begin
                if (psz == PD) m_drop++;
                else           pq.push_back(ctrl_tdata[31:16]);
            end
        end
    end

    bit           stall;
    logic [127:0] stall_data;

    always @(negedge clk) begin : monitor_p
        logic [127:0] e;
        if (rst) begin
            stall = 0;
        end else begin
            if (stall) begin
                chk("hold_valid", rec_tvalid, 1'b1);
                chk("hold_data", rec_tdata, stall_data);
            end
            if (rec_tvalid && rec_tready) begin
                chk("tlast", rec_tlast, 1'b1);
                if (sb.size() == 0) chk("unexpected_rec", rec_tdata, 128'd0 - 1);
                else begin
                    e = sb.pop_front();
                    chk("record", rec_tdata, e);
                end
            end
            stall = rec_tvalid && !rec_tready;
            stall_data = rec_tdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ctrl_tvalid = 1'b0;
        ts_tvalid   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic arm(input logic [15:0] tag, input logic [1:0] op);
        ctrl_tdata  = {tag, 14'd0, op};
        ctrl_tvalid = 1'b1;
        ctrl_tready = 1'b1;
    endtask

    task automatic ts(input logic [15:0] tag, input logic [79:0] t);
        ts_tdata  = {tag, t};
        ts_tvalid = 1'b1;
    endtask

    task automatic check_cnts(input string tagname);
        chk({tagname, "_match"}, cnt_match, m_match);
        chk({tagname, "_mismatch"}, cnt_mismatch, m_mismatch);
        chk({tagname, "_timeout"}, cnt_timeout, m_timeout);
        chk({tagname, "_orphan"}, cnt_orphan, m_orphan);
        chk({tagname, "_drop"}, cnt_drop, m_drop);
        chk({tagname, "_pend"}, pend_level, 7'(pq.size()));
    endtask

    task automatic wait_valid(input string name, input int want);
        int k;
        k = 0;
        while (k < 300) begin
            @(negedge clk);
            k++;
            if (rec_tvalid) break;
        end
        chk(name, k, want);
    endtask

    initial begin
        rst = 1'b1;
        ctrl_tdata = '0; ctrl_tvalid = 0; ctrl_tready = 0;
        ts_tdata = '0; ts_tvalid = 0; rec_tready = 1'b1;
        idle(3);
        rst = 1'b0;
        step();
        chk("rst_valid", rec_tvalid, 1'b0);
        chk("rst_last", rec_tlast, 1'b0);
        chk("rst_data", rec_tdata, 128'd0);
        check_cnts("rst");

        arm(16'h0005, 2'd2); step(); idle(3);
        ts(16'h0005, 80'h1234); step();
        wait_valid("match_latency", 2);
        idle(5);
        chk("match_cnt", cnt_match, 16'd1);
        check_cnts("p1");

        arm(16'h0007, 2'd1); step(); idle(2);
        ts(16'h0009, 80'($urandom)); step(); idle(5);
        chk("mism_cnt", cnt_mismatch, 16'd1);
        chk("mism_pend", pend_level, 7'd0);

        arm(16'h0011, 2'd3); step();
        wait_valid("timeout_latency", 102);
        idle(3);
        chk("tmo_cnt", cnt_timeout, 16'd1);

        ts(16'h0022, 80'h77); step(); idle(4);
        chk("orphan_cnt", cnt_orphan, 16'd1);

        for (int i = 0; i < 9; i++) begin arm(16'h0100 + 16'(i), 2'd1); step(); end
        step();
        chk("fill_pend", pend_level, 7'd8);
        chk("fill_drop", cnt_drop, 16'd1);
        for (int i = 0; i < 8; i++) begin ts(16'h0100 + 16'(i), 80'(i)); step(); end
        idle(5);
        chk("fill_match", cnt_match, 16'd9);
        check_cnts("p5");

        rec_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin ts(16'h0200 + 16'(i), 80'(i)); step(); end
        idle(3);
        chk("full_drop", cnt_drop, 16'd2);
        rec_tready = 1'b1;
        idle(20);
        ts(16'h0300, 80'h5); step(); idle(4);
        check_cnts("p6");

        arm(16'h0033, 2'd2); step();
        idle(99);
        ts(16'h0033, 80'hABC); step(); idle(5);
        chk("coinc_tmo", cnt_timeout, 16'd1);
        chk("coinc_match", cnt_match, 16'd10);

        for (int c = 0; c < 3000; c++) begin
            int tsp;
            tsp = ((c / 500) % 2 == 0) ? 4 : 150;
            if (c == 1500) begin
                rec_tready = 1'b0;
                rst = 1'b1;
                ts(16'h1, 80'h1); step();
                ts(16'h2, 80'h2); step();
                rst = 1'b0;
                step();
                chk("mid_rst_valid", rec_tvalid, 1'b0);
                check_cnts("mid_rst");
            end
            ctrl_tready = ($urandom_range(0, 3) != 0);
            ctrl_tvalid = ($urandom_range(0, 5) == 0);
            ctrl_tdata  = {16'($urandom_range(0, 3)), 14'($urandom), 2'($urandom)};
            ts_tvalid   = ($urandom_range(0, tsp - 1) == 0);
            ts_tdata    = {16'($urandom_range(0, 3)), 16'($urandom), 32'($urandom), 32'($urandom)};
            rec_tready  = ($urandom_range(0, 3) != 0);
            step();
        end
        rec_tready = 1'b1;
        idle(300);
        check_cnts("final");
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
